// File: rtl/bios_loader.sv
// bios_loader: boot-time copier of the BIOS image from flash into SD-RAM,
// one byte per read/write handshake pair, with per-transaction timeout.
module bios_loader #(
    parameter logic [23:0] SRC_ADDR   = 24'h10_0000,
    parameter logic [23:0] DST_ADDR   = 24'h70_0000,
    parameter logic [23:0] LENGTH     = 24'h02_4000,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    output logic        FLASH_RD,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_VALID,
    input  logic [7:0]  FLASH_RDATA,
    output logic        RAM_WR,
    output logic [23:0] RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    input  logic        RAM_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    // An empty image completes without touching either bus.
    localparam state_t S_GO = (LENGTH != '0) ? S_RD : S_DONE;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] count;
    logic [15:0] tmo;
    logic [7:0]  wdata;
    logic        first;
    logic        launch;
    logic        last;
    logic        tmo_hit;

    assign last    = (count == LENGTH - 24'd1);
    assign tmo_hit = (tmo == TIMEOUT);

    always_comb begin
        launch = 1'b0;
        unique case (state)
            S_IDLE:        launch = START | (first & AUTO_START);
            S_DONE, S_ERR: launch = START;
            default:       launch = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (launch) state_nxt = S_GO;
            end
            S_RD: begin
                if (FLASH_VALID)  state_nxt = S_WR;
                else if (tmo_hit) state_nxt = S_ERR;
            end
            S_WR: begin
                if (RAM_ACK)      state_nxt = last ? S_DONE : S_RD;
                else if (tmo_hit) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        FLASH_RD = (state == S_RD);
        RAM_WR   = (state == S_WR);
        BUSY     = (state == S_RD) || (state == S_WR);
        DONE     = (state == S_DONE);
        ERR      = (state == S_ERR);
    end

    // The failing byte's index is kept in count after a timeout.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            count <= '0;
            tmo   <= '0;
            wdata <= '0;
            first <= 1'b1;
        end else begin
            first <= 1'b0;
            if (launch) begin
                count <= '0;
                tmo   <= '0;
            end else if (state == S_RD) begin
                if (FLASH_VALID) begin
                    wdata <= FLASH_RDATA;
                    tmo   <= '0;
                end else if (!tmo_hit) begin
                    tmo <= tmo + 16'd1;
                end
            end else if (state == S_WR) begin
                if (RAM_ACK) begin
                    tmo <= '0;
                    if (!last) count <= count + 24'd1;
                end else if (!tmo_hit) begin
                    tmo <= tmo + 16'd1;
                end
            end
        end
    end

    assign FLASH_ADDR = SRC_ADDR + count;
    assign RAM_ADDR   = DST_ADDR + count;
    assign RAM_WDATA  = wdata;

endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: three copier instances (short image, wrapping source with
// random stalls, empty image) driven by randomized flash/RAM responders.
module tb_bios_loader;

    localparam logic [23:0] A_SRC = 24'h10_0000;
    localparam logic [23:0] B_SRC = 24'hFF_FFFE;
    localparam logic [23:0] DST   = 24'h70_0000;

    logic        clk;
    logic        rst_n;
    logic        start  [3];
    logic        frd    [3];
    logic        fvalid [3];
    logic [7:0]  frdata [3];
    logic [23:0] faddr  [3];
    logic        rwr    [3];
    logic [23:0] raddr  [3];
    logic [7:0]  rwdata [3];
    logic        rack   [3];
    logic        busy   [3];
    logic        done   [3];
    logic        err    [3];

    logic        prev_wr [3];
    logic [7:0]  prev_d  [3];
    logic        any_req [3];
    bit          ack_en  [3];
    int          fmax    [3];
    int          rmax    [3];
    int          fwait   [3];
    int          rwait   [3];
    int          idx     [3];
    int          wr_cnt  [3];
    int          wr_cyc  [3];
    int          busy_cnt[3];
    logic [23:0] m_fa;
    logic [23:0] m_ra;

    int n_chk  = 0;
    int n_fail = 0;

    bios_loader #(
        .SRC_ADDR(A_SRC), .DST_ADDR(DST), .LENGTH(24'd4),
        .TIMEOUT(16'd8), .AUTO_START(1'b1)
    ) u_a (
        .CLK(clk), .RESET_n(rst_n), .START(start[0]),
        .FLASH_RD(frd[0]), .FLASH_ADDR(faddr[0]),
        .FLASH_VALID(fvalid[0]), .FLASH_RDATA(frdata[0]),
        .RAM_WR(rwr[0]), .RAM_ADDR(raddr[0]),
        .RAM_WDATA(rwdata[0]), .RAM_ACK(rack[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    bios_loader #(
        .SRC_ADDR(B_SRC), .DST_ADDR(DST), .LENGTH(24'd16),
        .TIMEOUT(16'd30), .AUTO_START(1'b1)
    ) u_b (
        .CLK(clk), .RESET_n(rst_n), .START(start[1]),
        .FLASH_RD(frd[1]), .FLASH_ADDR(faddr[1]),
        .FLASH_VALID(fvalid[1]), .FLASH_RDATA(frdata[1]),
        .RAM_WR(rwr[1]), .RAM_ADDR(raddr[1]),
        .RAM_WDATA(rwdata[1]), .RAM_ACK(rack[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    bios_loader #(
        .SRC_ADDR(A_SRC), .DST_ADDR(DST), .LENGTH(24'd0),
        .TIMEOUT(16'hFFFF), .AUTO_START(1'b1)
    ) u_z (
        .CLK(clk), .RESET_n(rst_n), .START(start[2]),
        .FLASH_RD(frd[2]), .FLASH_ADDR(faddr[2]),
        .FLASH_VALID(fvalid[2]), .FLASH_RDATA(frdata[2]),
        .RAM_WR(rwr[2]), .RAM_ADDR(raddr[2]),
        .RAM_WDATA(rwdata[2]), .RAM_ACK(rack[2]),
        .BUSY(busy[2]), .DONE(done[2]), .ERR(err[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] src_of(input int i);
        return (i == 1) ? B_SRC : A_SRC;
    endfunction

    task automatic clear_model(input int i);
        idx[i]      = 0;
        wr_cnt[i]   = 0;
        wr_cyc[i]   = 0;
        busy_cnt[i] = 0;
        prev_wr[i]  = 1'b0;
    endtask

    task automatic pulse(input int i, input bit clr);
        start[i] = 1'b1;
        if (clr) clear_model(i);
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_end(input int i, input int budget);
        for (int n = 0; n < budget && !(done[i] || err[i]); n++)
            @(negedge clk);
    endtask

    // Memory-like responders plus scoreboard: k-th write of a copy must be
    // byte (SRC+k)[7:0] at DST+k; flash returns addr[7:0].
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            fvalid[i] = 1'b0;
            rack[i]   = 1'b0;
            if (rst_n) begin
                if (busy[i]) busy_cnt[i]++;
                if (rwr[i]) wr_cyc[i]++;
                if (frd[i] || rwr[i]) any_req[i] = 1'b1;
                if (rwr[i] && prev_wr[i])
                    check($sformatf("wdata_stable%0d", i),
                          32'(rwdata[i]), 32'(prev_d[i]));
                prev_wr[i] = rwr[i];
                prev_d[i]  = rwdata[i];
                m_fa = src_of(i) + 24'(idx[i]);
                m_ra = DST + 24'(idx[i]);
                if (frd[i]) begin
                    if (fwait[i] == 0) begin
                        check($sformatf("flash_addr%0d", i),
                              32'(faddr[i]), 32'(m_fa));
                        fvalid[i] = 1'b1;
                        frdata[i] = faddr[i][7:0];
                        fwait[i]  = $urandom_range(fmax[i], 0);
                    end else begin
                        fwait[i]--;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    fvalid[i] = 1'b1;
                    frdata[i] = 8'($urandom);
                end
                if (rwr[i]) begin
                    if (ack_en[i]) begin
                        if (rwait[i] == 0) begin
                            check($sformatf("ram_addr%0d", i),
                                  32'(raddr[i]), 32'(m_ra));
                            check($sformatf("ram_data%0d", i),
                                  32'(rwdata[i]), 32'(m_fa[7:0]));
                            rack[i]  = 1'b1;
                            idx[i]++;
                            wr_cnt[i]++;
                            rwait[i] = $urandom_range(rmax[i], 0);
                        end else begin
                            rwait[i]--;
                        end
                    end
                end else if (ack_en[i] && $urandom_range(3, 0) == 0) begin
                    rack[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i]   = 1'b0;
            frdata[i]  = 8'h00;
            ack_en[i]  = 1'b1;
            fmax[i]    = 0;
            rmax[i]    = 0;
            fwait[i]   = 0;
            rwait[i]   = 0;
            any_req[i] = 1'b0;
            prev_d[i]  = 8'h00;
            clear_model(i);
        end
        fmax[1]  = 20;
        rmax[1]  = 20;
        fwait[1] = $urandom_range(20, 0);
        repeat (3) @(negedge clk);

        check("rst_flash_rd", 32'(frd[0]), 32'd0);
        check("rst_ram_wr", 32'(rwr[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        check("rst_flash_addr", 32'(faddr[0]), 32'(A_SRC));
        check("rst_ram_addr", 32'(raddr[0]), 32'(DST));
        check("rst_wdata", 32'(rwdata[0]), 32'd0);
        check("rst_len0_done", 32'(done[2]), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("len0_done_1cyc", 32'(done[2]), 32'd1);
        check("auto_start_rd", 32'(frd[0]), 32'd1);

        wait_end(0, 200);
        check("t1_busy_cycles", 32'(busy_cnt[0]), 32'd8);
        check("t1_writes", 32'(wr_cnt[0]), 32'd4);
        check("t1_done", 32'(done[0]), 32'd1);
        check("t1_err", 32'(err[0]), 32'd0);

        wait_end(1, 3000);
        check("t2_writes", 32'(wr_cnt[1]), 32'd16);
        check("t2_done", 32'(done[1]), 32'd1);
        check("t2_err", 32'(err[1]), 32'd0);

        for (int r = 0; r < 2; r++) begin
            pulse(1, 1'b1);
            repeat (5) @(negedge clk);
            pulse(1, 1'b0);
            repeat (12) @(negedge clk);
            pulse(1, 1'b0);
            wait_end(1, 3000);
            check("t6_writes", 32'(wr_cnt[1]), 32'd16);
            check("t6_done", 32'(done[1]), 32'd1);
            check("t6_err", 32'(err[1]), 32'd0);
        end

        ack_en[0] = 1'b0;
        pulse(0, 1'b1);
        wait_end(0, 100);
        check("t3_err", 32'(err[0]), 32'd1);
        check("t3_wr_cycles", 32'(wr_cyc[0]), 32'd9);
        check("t3_ram_wr", 32'(rwr[0]), 32'd0);
        check("t3_busy", 32'(busy[0]), 32'd0);
        check("t3_done", 32'(done[0]), 32'd0);
        check("t3_writes", 32'(wr_cnt[0]), 32'd0);
        check("t3_ram_addr", 32'(raddr[0]), 32'(DST));
        ack_en[0] = 1'b1;
        pulse(0, 1'b1);
        wait_end(0, 200);
        check("t3_retry_done", 32'(done[0]), 32'd1);
        check("t3_retry_err", 32'(err[0]), 32'd0);
        check("t3_retry_writes", 32'(wr_cnt[0]), 32'd4);

        fmax[0] = 3;
        rmax[0] = 3;
        pulse(0, 1'b1);
        for (int n = 0; n < 200 && wr_cnt[0] < 2; n++)
            @(negedge clk);
        check("t4_progress", 32'(wr_cnt[0]), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_flash_rd", 32'(frd[0]), 32'd0);
        check("t4_ram_wr", 32'(rwr[0]), 32'd0);
        check("t4_busy", 32'(busy[0]), 32'd0);
        check("t4_done", 32'(done[0]), 32'd0);
        check("t4_flash_addr", 32'(faddr[0]), 32'(A_SRC));
        check("t4_wdata", 32'(rwdata[0]), 32'd0);
        for (int i = 0; i < 3; i++) clear_model(i);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_restart_rd", 32'(frd[0]), 32'd1);
        check("t4_restart_addr", 32'(faddr[0]), 32'(A_SRC));
        check("t4_len0_done", 32'(done[2]), 32'd1);
        wait_end(0, 300);
        check("t4_done_after", 32'(done[0]), 32'd1);
        check("t4_writes", 32'(wr_cnt[0]), 32'd4);
        wait_end(1, 3000);
        check("t4_b_writes", 32'(wr_cnt[1]), 32'd16);
        check("t4_b_done", 32'(done[1]), 32'd1);

        check("t5_no_requests", 32'(any_req[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
